trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_trigger_capture.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// -----------------------------------------------------------------------------
// trigger_capture
//
// Multi-channel oscilloscope-style capture buffer. After an arm pulse, incoming
// sample sets are written into a circular buffer (one memory per channel). The
// block first collects pre_len pre-trigger samples. It then waits for an edge
// on the selected channel, or for a timeout in auto mode, and finally collects
// the remaining post-trigger samples so that exactly DEPTH samples surround the
// trigger. The completed capture is held for readout until rd_done.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous active-low reset
//   sample_valid   : one-cycle strobe, sample_data holds a new sample set
//   sample_data    : CHANNELS x DATA_W, channel k at [k*DATA_W +: DATA_W]
//   trig_level     : trigger threshold (latched on arm)
//   trig_ch        : channel compared against trig_level (latched on arm)
//   edge_mode      : 00 rising, 01 falling, 10 either, 11 disabled
//   run_mode       : 00 normal, 01 auto, 10 single, 11 normal
//   pre_len        : pre-trigger sample count (latched, clamped to DEPTH-1)
//   arm            : one-cycle pulse, starts a capture from IDLE
//   rd_done        : one-cycle pulse, consumer releases a completed capture
//   rd_ch/rd_addr  : readout channel / index (0 = oldest captured sample)
//   rd_data        : readout sample, one cycle after rd_ch/rd_addr
//   ready          : a completed capture is held (DONE)
//   triggered_auto : in DONE, the capture was forced by the auto timeout
//   busy           : capture in progress (PREFILL, WAIT_TRIG, POST)
//   dbg_state      : current FSM state encoding, for observation only
//
// Handshake: sample_valid, arm and rd_done are single-cycle strobes sampled on
// the rising clock edge; there is no back-pressure. A sample is "accepted" only
// when sample_valid is high in PREFILL, WAIT_TRIG or POST. arm is honoured only
// in IDLE and rd_done only in DONE; rd_data follows rd_ch/rd_addr one cycle
// later and is meaningful only while ready is high.
// -----------------------------------------------------------------------------
module trigger_capture #(
   parameter int DATA_W   = 12,
   parameter int DEPTH    = 256,
   parameter int CHANNELS = 2,
   parameter int AUTO_TO  = 65535,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]   sample_data,
   input  logic [DATA_W-1:0]            trig_level,
   input  logic [CW-1:0]                trig_ch,
   input  logic [1:0]                   edge_mode,
   input  logic [1:0]                   run_mode,
   input  logic [AW-1:0]                pre_len,
   input  logic                         arm,
   input  logic                         rd_done,
   input  logic [CW-1:0]                rd_ch,
   input  logic [AW-1:0]                rd_addr,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         ready,
   output logic                         triggered_auto,
   output logic                         busy,
   output logic [2:0]                   dbg_state
);

   // Timeout counter only needs to reach AUTO_TO-1.
   localparam int TW = (AUTO_TO > 1) ? $clog2(AUTO_TO + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PREFILL = 3'd1,
      S_WAIT    = 3'd2,
      S_POST    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       trig_ptr_q, trig_ptr_d;
   logic [AW-1:0]       start_ptr_q, start_ptr_d;
   logic [AW-1:0]       pre_len_q, pre_len_d;
   logic [AW:0]         cnt_q, cnt_d;          // prefill count, then post count
   logic [TW-1:0]       to_cnt_q, to_cnt_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic                prev_valid_q, prev_valid_d;
   logic [DATA_W-1:0]   level_q, level_d;
   logic [CW-1:0]       trig_ch_q, trig_ch_d;
   logic [1:0]          edge_mode_q, edge_mode_d;
   logic [1:0]          run_mode_q, run_mode_d;
   logic                auto_q, auto_d;        // current capture was forced
   logic                ready_q, busy_q, ta_q;
   logic [DATA_W-1:0]   rd_data_q;

   logic [DATA_W-1:0]   mem [CHANNELS][DEPTH];

   logic                accept;
   logic [DATA_W-1:0]   cur;
   logic                rise, fall, edge_hit;
   logic                auto_mode, single_mode, timeout_hit;
   logic [AW:0]         post_target;
   logic [AW:0]         cnt_inc;
   logic [AW-1:0]       pre_len_eff;
   logic [CW-1:0]       rd_sel;
   logic [AW-1:0]       rd_idx;

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------
   assign accept = sample_valid &&
                   ((state_q == S_PREFILL) || (state_q == S_WAIT) || (state_q == S_POST));

   // Out-of-range channel selects fall back to channel 0.
   always_comb begin
      cur = sample_data[DATA_W-1:0];
      for (int k = 0; k < CHANNELS; k++) begin
         if (trig_ch_q == CW'(k)) begin
            cur = sample_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // prev is only meaningful once one sample has been accepted since arm.
   assign rise = prev_valid_q && (prev_q <  level_q) && (cur >= level_q);
   assign fall = prev_valid_q && (prev_q >= level_q) && (cur <  level_q);

   always_comb begin
      case (edge_mode_q)
         2'b00:   edge_hit = rise;
         2'b01:   edge_hit = fall;
         2'b10:   edge_hit = rise | fall;
         default: edge_hit = 1'b0;
      endcase
   end

   assign auto_mode   = (run_mode_q == 2'b01);
   assign single_mode = (run_mode_q == 2'b10);
   // The AUTO_TO-th accepted sample in WAIT_TRIG is the forced trigger sample.
   assign timeout_hit = auto_mode && (to_cnt_q == TW'(AUTO_TO - 1));

   // Post-trigger samples including the trigger sample itself.
   assign post_target = (AW+1)'(DEPTH) - {1'b0, pre_len_q};
   assign cnt_inc     = cnt_q + (AW+1)'(1);

   // At least one post sample (the trigger) must fit in the buffer.
   assign pre_len_eff = (pre_len >= AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : pre_len;

   assign rd_sel = (int'(rd_ch) < CHANNELS) ? rd_ch : '0;
   assign rd_idx = start_ptr_q + rd_addr;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      trig_ptr_d   = trig_ptr_q;
      start_ptr_d  = start_ptr_q;
      pre_len_d    = pre_len_q;
      cnt_d        = cnt_q;
      to_cnt_d     = to_cnt_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      level_d      = level_q;
      trig_ch_d    = trig_ch_q;
      edge_mode_d  = edge_mode_q;
      run_mode_d   = run_mode_q;
      auto_d       = auto_q;

      // Every accepted sample is stored and becomes the next edge reference.
      if (accept) begin
         wr_ptr_d     = wr_ptr_q + AW'(1);
         prev_d       = cur;
         prev_valid_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (arm) begin
               pre_len_d    = pre_len_eff;
               trig_ch_d    = trig_ch;
               edge_mode_d  = edge_mode;
               run_mode_d   = run_mode;
               level_d      = trig_level;
               cnt_d        = '0;
               to_cnt_d     = '0;
               prev_valid_d = 1'b0;
               auto_d       = 1'b0;
               // With no pre-trigger samples the trigger search starts at once.
               state_d      = (pre_len_eff == '0) ? S_WAIT : S_PREFILL;
            end
         end

         S_PREFILL: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == {1'b0, pre_len_q}) begin
                  state_d  = S_WAIT;
                  cnt_d    = '0;
                  to_cnt_d = '0;
               end
            end
         end

         S_WAIT: begin
            if (accept) begin
               if (edge_hit || timeout_hit) begin
                  trig_ptr_d = wr_ptr_q;
                  auto_d     = !edge_hit;
                  if (post_target == (AW+1)'(1)) begin
                     // Trigger sample is the only post sample: capture complete.
                     state_d     = S_DONE;
                     start_ptr_d = wr_ptr_q - pre_len_q;
                     cnt_d       = '0;
                  end else begin
                     state_d = S_POST;
                     cnt_d   = (AW+1)'(1);
                  end
               end else begin
                  to_cnt_d = to_cnt_q + TW'(1);
               end
            end
         end

         S_POST: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == post_target) begin
                  state_d     = S_DONE;
                  start_ptr_d = trig_ptr_q - pre_len_q;
                  cnt_d       = '0;
               end
            end
         end

         S_DONE: begin
            if (rd_done) begin
               cnt_d        = '0;
               to_cnt_d     = '0;
               prev_valid_d = 1'b0;
               auto_d       = 1'b0;
               if (single_mode) begin
                  state_d = S_IDLE;
               end else begin
                  // Rearm with the settings latched at the original arm.
                  state_d = (pre_len_q == '0) ? S_WAIT : S_PREFILL;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         trig_ptr_q   <= '0;
         start_ptr_q  <= '0;
         pre_len_q    <= '0;
         cnt_q        <= '0;
         to_cnt_q     <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         level_q      <= '0;
         trig_ch_q    <= '0;
         edge_mode_q  <= '0;
         run_mode_q   <= '0;
         auto_q       <= 1'b0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         ta_q         <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         trig_ptr_q   <= trig_ptr_d;
         start_ptr_q  <= start_ptr_d;
         pre_len_q    <= pre_len_d;
         cnt_q        <= cnt_d;
         to_cnt_q     <= to_cnt_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         level_q      <= level_d;
         trig_ch_q    <= trig_ch_d;
         edge_mode_q  <= edge_mode_d;
         run_mode_q   <= run_mode_d;
         auto_q       <= auto_d;
         // Status outputs are registered from the next state so they line up
         // with state_q exactly.
         ready_q      <= (state_d == S_DONE);
         busy_q       <= (state_d == S_PREFILL) || (state_d == S_WAIT) ||
                         (state_d == S_POST);
         ta_q         <= (state_d == S_DONE) && auto_d;
         rd_data_q    <= mem[rd_sel][rd_idx];
      end
   end

   // Sample memory: not reset, all channels written together.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < CHANNELS; k++) begin
            mem[k][wr_ptr_q] <= sample_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign rd_data        = rd_data_q;
   assign ready          = ready_q;
   assign busy           = busy_q;
   assign triggered_auto = ta_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_trigger_capture.sv
// -----------------------------------------------------------------------------
// tb_trigger_capture
//
// Directed bench for trigger_capture (DEPTH=256, CHANNELS=2, DATA_W=12,
// AUTO_TO=100). Status outputs are compared in the stimulus flow; readout
// requests push their hand-computed expected word into exp_q and a separate
// monitor pops and compares when the delayed read strobe says rd_data is due.
// -----------------------------------------------------------------------------
module tb_trigger_capture;

   localparam int DATA_W = 12;
   localparam int DEPTH  = 256;
   localparam int CH     = 2;
   localparam int AW     = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_PREFILL = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_POST    = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // ---------------------------------------------------------------------------
   // Clock / reset and DUT
   // ---------------------------------------------------------------------------
   logic                  clk;
   logic                  rst;
   logic                  sample_valid;
   logic [CH*DATA_W-1:0]  sample_data;
   logic [DATA_W-1:0]     trig_level;
   logic [0:0]            trig_ch;
   logic [1:0]            edge_mode;
   logic [1:0]            run_mode;
   logic [AW-1:0]         pre_len;
   logic                  arm;
   logic                  rd_done;
   logic [0:0]            rd_ch;
   logic [AW-1:0]         rd_addr;
   logic [DATA_W-1:0]     rd_data;
   logic                  ready;
   logic                  triggered_auto;
   logic                  busy;
   logic [2:0]            dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   trigger_capture #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .CHANNELS (CH),
      .AUTO_TO  (100)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sample_valid   (sample_valid),
      .sample_data    (sample_data),
      .trig_level     (trig_level),
      .trig_ch        (trig_ch),
      .edge_mode      (edge_mode),
      .run_mode       (run_mode),
      .pre_len        (pre_len),
      .arm            (arm),
      .rd_done        (rd_done),
      .rd_ch          (rd_ch),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .ready          (ready),
      .triggered_auto (triggered_auto),
      .busy           (busy),
      .dbg_state      (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int                n_checks = 0;
   int                n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   string             name_q[$];
   logic              rd_req = 1'b0;
   logic              rd_vld = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // rd_data is due one clock after the request was presented.
   always @(posedge clk) rd_vld <= rd_req;

   always @(negedge clk) begin : monitor
      logic [DATA_W-1:0] e;
      string             nm;
      if (rd_vld) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {20'd0, rd_data}, {20'd0, e});
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1);
      sample_valid = 1'b1;
      sample_data  = {c1, c0};
      tick();
      sample_valid = 1'b0;
   endtask

   // Ramp: ch0 = 16*i (12-bit wrap), ch1 = i.
   task automatic send_ramp(input int from, input int to);
      for (int i = from; i <= to; i++) send(DATA_W'(i * 16), DATA_W'(i));
   endtask

   // Square on ch1: 8 samples at 0xC00 then 8 at 0x100; ch0 = i.
   task automatic send_square(input int from, input int to);
      for (int i = from; i <= to; i++)
         send(DATA_W'(i), ((i % 16) < 8) ? 12'hC00 : 12'h100);
   endtask

   // ch0: low, then a PREFILL-only rise at 100, steady high into WAIT,
   // low for 260..262, rise again at 263; ch1 = i.
   task automatic send_t4(input int from, input int to);
      logic [DATA_W-1:0] v;
      for (int i = from; i <= to; i++) begin
         if (i < 100)                  v = 12'h100;
         else if (i < 260)             v = 12'h900;
         else if (i < 263)             v = 12'h100;
         else                          v = 12'h900;
         send(v, DATA_W'(i));
      end
   endtask

   task automatic do_arm(input logic [AW-1:0] pl, input logic tch, input logic [1:0] em,
                         input logic [1:0] rm, input logic [DATA_W-1:0] lvl);
      pre_len    = pl;
      trig_ch    = tch;
      edge_mode  = em;
      run_mode   = rm;
      trig_level = lvl;
      arm        = 1'b1;
      tick();
      arm        = 1'b0;
   endtask

   task automatic pulse_rd_done();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   task automatic rd(input logic ch, input logic [AW-1:0] addr,
                     input logic [DATA_W-1:0] exp_v, input string name);
      rd_ch   = ch;
      rd_addr = addr;
      rd_req  = 1'b1;
      exp_q.push_back(exp_v);
      name_q.push_back(name);
      tick();
      rd_req  = 1'b0;
   endtask

   task automatic drain();
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
      trig_level   = '0;
      trig_ch      = '0;
      edge_mode    = '0;
      run_mode     = '0;
      pre_len      = '0;
      arm          = 1'b0;
      rd_done      = 1'b0;
      rd_ch        = '0;
      rd_addr      = '0;
      #2;
      rst = 1'b0;
      repeat (3) tick();
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_tauto", triggered_auto, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // T1: normal, rising, level 0x800, pre_len 64, ramp. Edge at i=128,
      // DONE after sample 319, start_ptr = 64.
      do_arm(8'd64, 1'b0, 2'b00, 2'b00, 12'h800);
      check("t1_busy_after_arm", busy, 1);
      send_ramp(0, 9);
      pre_len = 8'd5;                 // arm while busy must not relatch
      arm = 1'b1;
      tick();
      arm = 1'b0;
      pre_len = 8'd64;
      send_ramp(10, 318);
      check("t1_not_ready_318", ready, 0);
      check("t1_state_post", dbg_state, ST_POST);
      send_ramp(319, 319);
      check("t1_ready", ready, 1);
      check("t1_busy_done", busy, 0);
      check("t1_tauto", triggered_auto, 0);
      send(12'hABC, 12'hABC);         // ignored in DONE
      send(12'hABC, 12'hABC);
      rd(1'b0, 8'd64,  12'h800, "t1_trig_sample");
      rd(1'b0, 8'd63,  12'h7F0, "t1_pre_last");
      rd(1'b0, 8'd0,   12'h400, "t1_oldest");
      rd(1'b0, 8'd255, 12'h3F0, "t1_newest");
      rd(1'b1, 8'd64,  12'h080, "t1_ch1_trig");
      rd(1'b1, 8'd0,   12'h040, "t1_ch1_oldest");
      drain();
      pulse_rd_done();
      check("t1_rearm_busy", busy, 1);
      check("t1_rearm_ready", ready, 0);
      check("t1_rearm_state", dbg_state, ST_PREFILL);
      do_reset();

      // T2: single, falling, level 0x400, pre_len 0, trig_ch 1, square on ch1.
      // Edge at i=8, DONE after sample 263, start_ptr = 8.
      do_arm(8'd0, 1'b1, 2'b01, 2'b10, 12'h400);
      check("t2_state_wait", dbg_state, ST_WAIT);
      send_square(0, 262);
      check("t2_not_ready_262", ready, 0);
      send_square(263, 263);
      check("t2_ready", ready, 1);
      rd(1'b1, 8'd0,   12'h100, "t2_first_low");
      rd(1'b0, 8'd0,   12'h008, "t2_ch0_aligned");
      rd(1'b0, 8'd255, 12'h107, "t2_ch0_newest");
      rd(1'b1, 8'd8,   12'hC00, "t2_next_high");
      rd(1'b1, 8'd7,   12'h100, "t2_last_low");
      drain();
      pulse_rd_done();
      check("t2_single_idle", dbg_state, ST_IDLE);
      check("t2_single_ready", ready, 0);
      check("t2_single_busy", busy, 0);

      // T3: auto, pre_len 10, constant 0x123 never crosses 0x800.
      // DONE after 10 + 100 + 245 = 355 samples.
      do_arm(8'd10, 1'b0, 2'b00, 2'b01, 12'h800);
      for (int i = 0; i < 354; i++) send(12'h123, 12'h123);
      check("t3_not_ready_354", ready, 0);
      check("t3_busy_354", busy, 1);
      send(12'h123, 12'h123);
      check("t3_ready", ready, 1);
      check("t3_tauto", triggered_auto, 1);
      rd(1'b0, 8'd0,   12'h123, "t3_w0");
      rd(1'b0, 8'd10,  12'h123, "t3_w10");
      rd(1'b0, 8'd255, 12'h123, "t3_w255");
      rd(1'b1, 8'd100, 12'h123, "t3_ch1_w100");
      drain();
      pulse_rd_done();
      check("t3_rearm_busy", busy, 1);
      check("t3_rearm_tauto", triggered_auto, 0);
      check("t3_rearm_state", dbg_state, ST_PREFILL);
      do_reset();

      // T4: single, rising 0x800, pre_len 255. PREFILL-only edge at i=100 is
      // ignored; trigger at i=263 (addr 7), start_ptr = 8 after wrap.
      do_arm(8'd255, 1'b0, 2'b00, 2'b10, 12'h800);
      send_t4(0, 259);
      check("t4_no_prefill_trig", dbg_state, ST_WAIT);
      pulse_rd_done();                // ignored outside DONE
      check("t4_rd_done_ignored", dbg_state, ST_WAIT);
      send_t4(260, 262);
      check("t4_not_ready_262", ready, 0);
      send_t4(263, 263);
      check("t4_ready", ready, 1);
      rd(1'b0, 8'd255, 12'h900, "t4_trig_sample");
      rd(1'b0, 8'd254, 12'h100, "t4_pre_last");
      rd(1'b0, 8'd251, 12'h900, "t4_wait_high");
      rd(1'b0, 8'd0,   12'h100, "t4_oldest");
      rd(1'b1, 8'd0,   12'h008, "t4_ch1_oldest");
      rd(1'b1, 8'd255, 12'h107, "t4_ch1_newest");
      drain();
      arm     = 1'b1;                 // arm + rd_done together: rd_done wins
      rd_done = 1'b1;
      tick();
      arm     = 1'b0;
      rd_done = 1'b0;
      check("t4_both_idle", dbg_state, ST_IDLE);
      check("t4_both_busy", busy, 0);

      // T5: reset during POST aborts; then a clean capture in mode 11
      // (normal), either edge, level 0x200, pre_len 16. Edge at i=32.
      do_arm(8'd4, 1'b0, 2'b00, 2'b00, 12'h800);
      send_ramp(0, 139);
      check("t5_in_post", dbg_state, ST_POST);
      rst = 1'b0;
      #2;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_ready", ready, 0);
      check("t5_rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst = 1'b1;
      tick();
      do_arm(8'd16, 1'b0, 2'b10, 2'b11, 12'h200);
      send_ramp(0, 270);
      check("t5_not_ready_270", ready, 0);
      send_ramp(271, 271);
      check("t5_ready", ready, 1);
      check("t5_tauto", triggered_auto, 0);
      rd(1'b0, 8'd16,  12'h200, "t5_trig_sample");
      rd(1'b0, 8'd15,  12'h1F0, "t5_pre_last");
      rd(1'b0, 8'd0,   12'h100, "t5_oldest");
      rd(1'b0, 8'd255, 12'h0F0, "t5_newest");
      rd(1'b1, 8'd16,  12'h020, "t5_ch1_trig");
      drain();
      pulse_rd_done();
      check("t5_mode3_rearm", dbg_state, ST_PREFILL);
      check("t5_mode3_busy", busy, 1);

      drain();
      check("rd_queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Safety net: the directed flow needs only a few thousand cycles.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
